audio_sample_fifo: RTL and testbench

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

---
 rtl/audio_sample_fifo_if.sv | 24 ++
 rtl/audio_sample_fifo.sv | 81 ++++++++
 tb/tb_audio_sample_fifo.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_sample_fifo_if.sv
// Sample handshake between the CPU bus writer, the FIFO and the I2S serializer.
// The master modport is the side that drives the requests; slave is the FIFO.
interface audio_sample_fifo_if #(
  parameter int SW = 24
);
  logic [SW-1:0] adau_audio_l;
  logic [SW-1:0] adau_audio_r;
  logic          adau_audio_valid;
  logic          adau_audio_full;
  logic          sample_req;
  logic [SW-1:0] sample_l;
  logic [SW-1:0] sample_r;
  logic          sample_valid;

  modport master (
    output adau_audio_l, adau_audio_r, adau_audio_valid, sample_req,
    input  adau_audio_full, sample_l, sample_r, sample_valid
  );

  modport slave (
    input  adau_audio_l, adau_audio_r, adau_audio_valid, sample_req,
    output adau_audio_full, sample_l, sample_r, sample_valid
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO between the CPU bus writer and the I2S serializer.
// An empty read still strobes sample_valid with the previous data and flags underrun.
module audio_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int SW    = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  audio_sample_fifo_if.slave       bus,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  input  logic                     underrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [2*SW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            wr_en;
  logic            rd_en;
  logic [LW-1:0]   level_nxt;
  logic [SW-1:0]   out_l;
  logic [SW-1:0]   out_r;
  logic            out_valid;

  assign bus.adau_audio_full = full;
  assign bus.sample_l        = out_l;
  assign bus.sample_r        = out_r;
  assign bus.sample_valid    = out_valid;

  always_comb begin
    wr_en     = bus.adau_audio_valid & ~full;
    rd_en     = bus.sample_req & ~empty;
    level_nxt = level;
    if (wr_en && !rd_en)
      level_nxt = level + LW'(1);
    else if (rd_en && !wr_en)
      level_nxt = level - LW'(1);
  end

  // Storage is kept out of the reset domain so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {bus.adau_audio_l, bus.adau_audio_r};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr         <= rd_ptr + AW'(1);
        {out_l, out_r} <= mem[rd_ptr];
      end
      level     <= level_nxt;
      empty     <= (level_nxt == '0);
      full      <= (level_nxt == LW'(DEPTH));
      out_valid <= bus.sample_req;
      // A new underrun on the same edge as a clear keeps the flag set.
      if (bus.sample_req && empty)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo (DEPTH=16, SW=24); inputs change 1 time unit
// after the rising edge and outputs are sampled at the same point.
module tb_audio_sample_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       empty;
  logic [4:0] level;
  logic       underrun;
  logic       underrun_clr;

  int passed = 0;
  int total  = 0;

  audio_sample_fifo_if #(.SW(24)) bus ();

  audio_sample_fifo #(.DEPTH(16), .SW(24)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .empty        (empty),
    .level        (level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.adau_audio_l     = '0;
    bus.adau_audio_r     = '0;
    bus.adau_audio_valid = 1'b0;
    bus.sample_req       = 1'b0;
    underrun_clr         = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    idle();
    reset = 1'b1;
    #1;
    tick();
    total++; if (level !== 5'd0) $display("FAIL reset_level got %0d exp 0", level); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else passed++;
    total++; if (bus.adau_audio_full !== 1'b0) $display("FAIL reset_full got %b exp 0", bus.adau_audio_full); else passed++;
    total++; if (bus.sample_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.sample_valid); else passed++;
    total++; if ({bus.sample_l, bus.sample_r} !== 48'h0) $display("FAIL reset_data got %h exp 0", {bus.sample_l, bus.sample_r}); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b exp 0", underrun); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    logic [23:0] exp_l, exp_r;
    for (int i = 0; i < 3; i++) begin
      bus.adau_audio_l     = 24'(24'h000001 + i);
      bus.adau_audio_r     = 24'(24'h100001 + i);
      bus.adau_audio_valid = 1'b1;
      tick();
      total++; if (level !== 5'(i + 1)) $display("FAIL basic_wr_level%0d got %0d exp %0d", i, level, i + 1); else passed++;
    end
    bus.adau_audio_valid = 1'b0;
    total++; if (empty !== 1'b0) $display("FAIL basic_not_empty got %b exp 0", empty); else passed++;
    for (int i = 0; i < 3; i++) begin
      exp_l = 24'(24'h000001 + i);
      exp_r = 24'(24'h100001 + i);
      bus.sample_req = 1'b1;
      tick();
      bus.sample_req = 1'b0;
      total++; if (bus.sample_valid !== 1'b1) $display("FAIL basic_valid%0d got %b exp 1", i, bus.sample_valid); else passed++;
      total++; if (bus.sample_l !== exp_l) $display("FAIL basic_l%0d got %h exp %h", i, bus.sample_l, exp_l); else passed++;
      total++; if (bus.sample_r !== exp_r) $display("FAIL basic_r%0d got %h exp %h", i, bus.sample_r, exp_r); else passed++;
      total++; if (level !== 5'(2 - i)) $display("FAIL basic_rd_level%0d got %0d exp %0d", i, level, 2 - i); else passed++;
      tick();
      total++; if (bus.sample_valid !== 1'b0) $display("FAIL basic_strobe%0d got %b exp 0", i, bus.sample_valid); else passed++;
    end
    total++; if (empty !== 1'b1) $display("FAIL basic_empty got %b exp 1", empty); else passed++;
  endtask

  task automatic test_full;
    logic [23:0] exp_l;
    for (int i = 0; i < 16; i++) begin
      bus.adau_audio_l     = 24'(24'h000100 + i);
      bus.adau_audio_r     = 24'(24'h200100 + i);
      bus.adau_audio_valid = 1'b1;
      tick();
    end
    total++; if (level !== 5'd16) $display("FAIL full_level got %0d exp 16", level); else passed++;
    total++; if (bus.adau_audio_full !== 1'b1) $display("FAIL full_flag got %b exp 1", bus.adau_audio_full); else passed++;
    bus.adau_audio_l = 24'hABCDEF;
    bus.adau_audio_r = 24'h5A5A5A;
    tick();
    total++; if (level !== 5'd16) $display("FAIL full_held_level got %0d exp 16", level); else passed++;
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    total++; if (bus.sample_l !== 24'h000100) $display("FAIL full_first_l got %h exp 000100", bus.sample_l); else passed++;
    total++; if (level !== 5'd15) $display("FAIL full_after_rd_level got %0d exp 15", level); else passed++;
    total++; if (bus.adau_audio_full !== 1'b0) $display("FAIL full_drop got %b exp 0", bus.adau_audio_full); else passed++;
    tick();
    bus.adau_audio_valid = 1'b0;
    total++; if (level !== 5'd16) $display("FAIL full_held_lands got %0d exp 16", level); else passed++;
    total++; if (bus.adau_audio_full !== 1'b1) $display("FAIL full_reassert got %b exp 1", bus.adau_audio_full); else passed++;
    for (int k = 0; k < 16; k++) begin
      exp_l = (k < 15) ? 24'(24'h000101 + k) : 24'hABCDEF;
      bus.sample_req = 1'b1;
      tick();
      bus.sample_req = 1'b0;
      total++; if (bus.sample_l !== exp_l) $display("FAIL full_drain_l%0d got %h exp %h", k, bus.sample_l, exp_l); else passed++;
      tick();
    end
    total++; if (bus.sample_r !== 24'h5A5A5A) $display("FAIL full_held_r got %h exp 5a5a5a", bus.sample_r); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL full_drain_empty got %b exp 1", empty); else passed++;
  endtask

  task automatic test_underrun;
    do_reset();
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    total++; if (bus.sample_valid !== 1'b1) $display("FAIL ur_valid got %b exp 1", bus.sample_valid); else passed++;
    total++; if ({bus.sample_l, bus.sample_r} !== 48'h0) $display("FAIL ur_data got %h exp 0", {bus.sample_l, bus.sample_r}); else passed++;
    total++; if (underrun !== 1'b1) $display("FAIL ur_set got %b exp 1", underrun); else passed++;
    total++; if (level !== 5'd0) $display("FAIL ur_level got %0d exp 0", level); else passed++;
    tick();
    total++; if (underrun !== 1'b1) $display("FAIL ur_sticky got %b exp 1", underrun); else passed++;
    total++; if (bus.sample_valid !== 1'b0) $display("FAIL ur_strobe got %b exp 0", bus.sample_valid); else passed++;
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    total++; if (underrun !== 1'b0) $display("FAIL ur_clear got %b exp 0", underrun); else passed++;
    underrun_clr   = 1'b1;
    bus.sample_req = 1'b1;
    tick();
    underrun_clr   = 1'b0;
    bus.sample_req = 1'b0;
    total++; if (underrun !== 1'b1) $display("FAIL ur_set_wins got %b exp 1", underrun); else passed++;
    // Previous data must survive an underrun read.
    bus.adau_audio_l     = 24'h777777;
    bus.adau_audio_r     = 24'h888888;
    bus.adau_audio_valid = 1'b1;
    tick();
    bus.adau_audio_valid = 1'b0;
    bus.sample_req       = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    tick();
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    total++; if (bus.sample_valid !== 1'b1) $display("FAIL ur_hold_valid got %b exp 1", bus.sample_valid); else passed++;
    total++; if ({bus.sample_l, bus.sample_r} !== 48'h777777888888) $display("FAIL ur_hold_data got %h exp 777777888888", {bus.sample_l, bus.sample_r}); else passed++;
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    bus.adau_audio_l     = 24'h444444;
    bus.adau_audio_r     = 24'h555555;
    bus.adau_audio_valid = 1'b1;
    bus.sample_req       = 1'b1;
    tick();
    bus.adau_audio_valid = 1'b0;
    bus.sample_req       = 1'b0;
    total++; if (underrun !== 1'b1) $display("FAIL ur_wr_coinc_flag got %b exp 1", underrun); else passed++;
    total++; if (level !== 5'd1) $display("FAIL ur_wr_coinc_level got %0d exp 1", level); else passed++;
    total++; if (empty !== 1'b0) $display("FAIL ur_wr_coinc_empty got %b exp 0", empty); else passed++;
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    total++; if (bus.sample_l !== 24'h444444) $display("FAIL ur_wr_coinc_data got %h exp 444444", bus.sample_l); else passed++;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [23:0] q[$];
    logic [23:0] exp_l;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.adau_audio_l     = 24'(24'h300000 + k);
      bus.adau_audio_r     = 24'(24'h400000 + k);
      bus.adau_audio_valid = 1'b1;
      q.push_back(24'(24'h300000 + k));
      tick();
    end
    total++; if (level !== 5'd5) $display("FAIL b2b_start_level got %0d exp 5", level); else passed++;
    for (int c = 0; c < 40; c++) begin
      bus.adau_audio_l     = 24'(24'h300005 + c);
      bus.adau_audio_r     = 24'(24'h400005 + c);
      bus.adau_audio_valid = 1'b1;
      bus.sample_req       = 1'b1;
      q.push_back(24'(24'h300005 + c));
      tick();
      exp_l = q.pop_front();
      total++; if (bus.sample_valid !== 1'b1 || bus.sample_l !== exp_l) $display("FAIL b2b_data%0d got %b/%h exp 1/%h", c, bus.sample_valid, bus.sample_l, exp_l); else passed++;
      total++; if (level !== 5'd5) $display("FAIL b2b_level%0d got %0d exp 5", c, level); else passed++;
    end
    bus.adau_audio_valid = 1'b0;
    bus.sample_req       = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.sample_req = 1'b1;
      tick();
      bus.sample_req = 1'b0;
      exp_l = q.pop_front();
      total++; if ({bus.sample_l, bus.sample_r} !== {exp_l, exp_l + 24'h100000}) $display("FAIL b2b_drain%0d got %h exp %h", k, {bus.sample_l, bus.sample_r}, {exp_l, exp_l + 24'h100000}); else passed++;
      tick();
    end
    total++; if (empty !== 1'b1) $display("FAIL b2b_empty got %b exp 1", empty); else passed++;
  endtask

  task automatic test_async_reset;
    for (int k = 0; k < 8; k++) begin
      bus.adau_audio_l     = 24'(24'h500001 + k);
      bus.adau_audio_r     = 24'(24'h600001 + k);
      bus.adau_audio_valid = 1'b1;
      tick();
    end
    bus.adau_audio_valid = 1'b0;
    total++; if (level !== 5'd8) $display("FAIL ar_load_level got %0d exp 8", level); else passed++;
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    total++; if (bus.sample_l !== 24'h500001) $display("FAIL ar_pre_l got %h exp 500001", bus.sample_l); else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus.sample_valid !== 1'b0) $display("FAIL ar_valid got %b exp 0", bus.sample_valid); else passed++;
    total++; if ({bus.sample_l, bus.sample_r} !== 48'h0) $display("FAIL ar_data got %h exp 0", {bus.sample_l, bus.sample_r}); else passed++;
    total++; if (level !== 5'd0) $display("FAIL ar_level got %0d exp 0", level); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL ar_empty got %b exp 1", empty); else passed++;
    total++; if (bus.adau_audio_full !== 1'b0) $display("FAIL ar_full got %b exp 0", bus.adau_audio_full); else passed++;
    tick();
    #2;
    reset          = 1'b0;
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    total++; if (underrun !== 1'b1) $display("FAIL ar_underrun got %b exp 1", underrun); else passed++;
    total++; if (bus.sample_valid !== 1'b1) $display("FAIL ar_post_valid got %b exp 1", bus.sample_valid); else passed++;
    total++; if ({bus.sample_l, bus.sample_r} !== 48'h0) $display("FAIL ar_post_data got %h exp 0", {bus.sample_l, bus.sample_r}); else passed++;
    total++; if (level !== 5'd0) $display("FAIL ar_post_level got %0d exp 0", level); else passed++;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_full();
    test_underrun();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
